sprite_anim_sequencer: RTL and testbench

- Sequences animation-frame selects for cannon, enemies and alien laser, driving the sprite ROM select inputs. Those selects then index pixel colours through the palette.
- Advances only on a one-cycle frame_tick (one per vsync) while game_run is high; hit/blast events come from collision logic.
- Replaces the static default selects with timed animation.

---
 rtl/sprite_pkg.sv | 33 +++
 rtl/frame_countdown.sv | 37 +++
 rtl/sprite_anim_sequencer.sv | 249 ++++++++++++++++++++++++
 tb/tb_sprite_anim_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types and select codes for the sprite animation sequencer.
//   cannon_state_t  - cannon life-cycle states (ALIVE / EXPLODE / RESPAWN)
//   CANNON_*        - choose_cannon select codes
//   LASER_BLAST     - choose_laser code for the impact sprite
//   ENEMY_BLAST     - choose_enemy code for the explosion sprite
//   CNT_W           - width of every frame counter
//   enemy_sel()     - maps enemy type + march frame bit to a sprite ROM select
package sprite_pkg;

  typedef enum logic [1:0] {
    ALIVE   = 2'd0,
    EXPLODE = 2'd1,
    RESPAWN = 2'd2
  } cannon_state_t;

  localparam logic [1:0] CANNON_NORMAL = 2'd0;
  localparam logic [1:0] CANNON_EXPL_A = 2'd1;
  localparam logic [1:0] CANNON_EXPL_B = 2'd2;
  localparam logic [1:0] CANNON_BLANK  = 2'd3;

  localparam logic [2:0] LASER_BLAST = 3'd4;
  localparam logic [3:0] ENEMY_BLAST = 4'd6;

  localparam int CNT_W = 8;

  // Type 3 has no sprite pair of its own and falls back to the 10pt sprites.
  function automatic logic [3:0] enemy_sel(input logic [1:0] etype, input logic frame);
    logic [1:0] t;
    t = (etype == 2'd3) ? 2'd0 : etype;
    return {1'b0, t, frame};
  endfunction

endpackage

// File: rtl/frame_countdown.sv
// frame_countdown: loadable down-counter measured in advance (frame) cycles.
//   Clk, Reset_n  - clock, asynchronous active-low reset (count clears to 0)
//   load/load_val - start a new countdown of load_val advances; beats adv
//   adv           - one advance opportunity (frame tick while running)
//   active        - count is nonzero (the timed state is showing)
//   expire        - this adv is the last one of the countdown (count == 1)
// A load of N keeps active high for exactly N advances. expire is not masked
// by load so that a caller may reload on expire without a combinational loop;
// callers that can load while counting decide themselves which one wins.
module frame_countdown
  import sprite_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             adv,
  output logic             active,
  output logic             expire
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (adv && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign active = (count_q != '0);
  assign expire = adv && (count_q == CNT_W'(1));

endmodule

// File: rtl/sprite_anim_sequencer.sv
// sprite_anim_sequencer: timed sprite ROM selects for cannon, enemies and the
// alien laser. Animation advances once per frame_tick while game_run is high;
// hit/blast pulses from the collision logic are accepted at any time.
//   Clk, Reset_n     - clock, asynchronous active-low reset
//   frame_tick       - one-Clk pulse per video frame
//   game_run         - 1 = animation advances, 0 = timers frozen
//   enemy_type       - 0=10pt, 1=20pt, 2=30pt, 3 treated as 0
//   enemy_hit        - start / restart the enemy explosion
//   cannon_hit       - start the cannon explosion (ALIVE only)
//   laser_active     - alien laser in flight
//   laser_blast      - alien laser impact
//   choose_cannon    - 0 normal, 1 explode A, 2 explode B, 3 blank
//   choose_laser     - 0..3 flight frames, 4 blast
//   choose_enemy     - enemy_type*2 + frame bit, 6 while exploding
//   enemy_step       - one-Clk pulse on each march step
//   cannon_busy      - cannon not ALIVE
//   dbg_cannon_state - current cannon FSM state
// Every select is a decode of registered state, so events appear one Clk after
// the input edge.
module sprite_anim_sequencer
  import sprite_pkg::*;
#(
  parameter int ENEMY_STEP_FRAMES  = 16,
  parameter int ENEMY_BLAST_FRAMES = 8,
  parameter int EXPL_FRAMES        = 60,
  parameter int EXPL_TOGGLE_FRAMES = 4,
  parameter int RESPAWN_FRAMES     = 120,
  parameter int LASER_STEP_FRAMES  = 4,
  parameter int LASER_BLAST_FRAMES = 6
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic       game_run,
  input  logic [1:0] enemy_type,
  input  logic       enemy_hit,
  input  logic       cannon_hit,
  input  logic       laser_active,
  input  logic       laser_blast,
  output logic [1:0] choose_cannon,
  output logic [2:0] choose_laser,
  output logic [3:0] choose_enemy,
  output logic       enemy_step,
  output logic       cannon_busy,
  output logic [1:0] dbg_cannon_state
);

  logic adv;
  assign adv = frame_tick & game_run;

  // ---------------------------------------------------------------- enemies
  logic eb_active, eb_expire;

  frame_countdown u_enemy_blast (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .load     (enemy_hit),
    .load_val (CNT_W'(ENEMY_BLAST_FRAMES)),
    .adv      (adv),
    .active   (eb_active),
    .expire   (eb_expire)
  );

  logic [CNT_W-1:0] step_q;
  logic             frame_q;
  logic             enemy_step_q;
  logic             march_adv;
  logic             march_wrap;

  // The march holds while an explosion is showing, including the cycle a hit
  // arrives, so the step count resumes exactly where it was.
  assign march_adv  = adv & ~eb_active & ~enemy_hit;
  assign march_wrap = march_adv & (step_q == CNT_W'(ENEMY_STEP_FRAMES - 1));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      step_q       <= '0;
      frame_q      <= 1'b0;
      enemy_step_q <= 1'b0;
    end else begin
      enemy_step_q <= march_wrap;
      if (march_wrap) begin
        step_q  <= '0;
        frame_q <= ~frame_q;
      end else if (march_adv) begin
        step_q <= step_q + 1'b1;
      end
    end
  end

  // enemy_type is registered; until the first Clk after reset there is no
  // sampled value yet, so the live input is shown instead.
  logic [1:0] type_q;
  logic       type_valid_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      type_q       <= 2'd0;
      type_valid_q <= 1'b0;
    end else begin
      type_q       <= enemy_type;
      type_valid_q <= 1'b1;
    end
  end

  assign choose_enemy = eb_active ? ENEMY_BLAST
                                  : enemy_sel(type_valid_q ? type_q : enemy_type, frame_q);
  assign enemy_step   = enemy_step_q;

  // ----------------------------------------------------------------- cannon
  cannon_state_t state_q, state_d;
  logic          phase_q, phase_d;   // 0 = explode A, 1 = explode B
  logic          total_load, tog_load, resp_load;
  logic          total_active, total_expire;
  logic          tog_active, tog_expire;
  logic          resp_active, resp_expire;
  logic          explode_adv, respawn_adv;

  assign explode_adv = adv & (state_q == EXPLODE);
  assign respawn_adv = adv & (state_q == RESPAWN);

  frame_countdown u_cannon_total (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .load     (total_load),
    .load_val (CNT_W'(EXPL_FRAMES)),
    .adv      (explode_adv),
    .active   (total_active),
    .expire   (total_expire)
  );

  frame_countdown u_cannon_toggle (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .load     (tog_load),
    .load_val (CNT_W'(EXPL_TOGGLE_FRAMES)),
    .adv      (explode_adv),
    .active   (tog_active),
    .expire   (tog_expire)
  );

  frame_countdown u_cannon_respawn (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .load     (resp_load),
    .load_val (CNT_W'(RESPAWN_FRAMES)),
    .adv      (respawn_adv),
    .active   (resp_active),
    .expire   (resp_expire)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ALIVE;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    total_load    = 1'b0;
    tog_load      = 1'b0;
    resp_load     = 1'b0;
    choose_cannon = CANNON_NORMAL;
    case (state_q)
      ALIVE: begin
        choose_cannon = CANNON_NORMAL;
        if (cannon_hit) begin
          state_d    = EXPLODE;
          phase_d    = 1'b0;
          total_load = 1'b1;
          tog_load   = 1'b1;
        end
      end
      EXPLODE: begin
        choose_cannon = phase_q ? CANNON_EXPL_B : CANNON_EXPL_A;
        // End of the explosion wins over a coincident A/B toggle.
        if (total_expire) begin
          state_d   = RESPAWN;
          resp_load = 1'b1;
        end else if (tog_expire) begin
          phase_d  = ~phase_q;
          tog_load = 1'b1;
        end
      end
      RESPAWN: begin
        choose_cannon = CANNON_BLANK;
        if (resp_expire) begin
          state_d = ALIVE;
        end
      end
      default: begin
        state_d = ALIVE;
      end
    endcase
  end

  assign cannon_busy      = (state_q != ALIVE);
  assign dbg_cannon_state = state_q;

  // ------------------------------------------------------------------ laser
  logic lb_active, lb_expire;

  frame_countdown u_laser_blast (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .load     (laser_blast),
    .load_val (CNT_W'(LASER_BLAST_FRAMES)),
    .adv      (adv),
    .active   (lb_active),
    .expire   (lb_expire)
  );

  logic [CNT_W-1:0] lstep_q;
  logic [1:0]       lframe_q;
  logic             fly_adv;

  assign fly_adv = adv & laser_active & ~lb_active & ~laser_blast;

  // An impact restarts the flight animation so that frame 0 follows the blast.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      lstep_q  <= '0;
      lframe_q <= 2'd0;
    end else if (!laser_active || laser_blast) begin
      lstep_q  <= '0;
      lframe_q <= 2'd0;
    end else if (fly_adv) begin
      if (lstep_q == CNT_W'(LASER_STEP_FRAMES - 1)) begin
        lstep_q  <= '0;
        lframe_q <= lframe_q + 1'b1;
      end else begin
        lstep_q <= lstep_q + 1'b1;
      end
    end
  end

  assign choose_laser = lb_active ? LASER_BLAST : {1'b0, lframe_q};

  // These counter flags carry no information beyond the FSM state / select
  // decodes above.
  logic unused_flags;
  assign unused_flags = ^{eb_expire, lb_expire, total_active, tog_active, resp_active};

endmodule

// File: tb/tb_sprite_anim_sequencer.sv
// Bench for sprite_anim_sequencer: per-feature test tasks, expected select
// codes queued as each frame tick is driven and compared once it has landed.
module tb_sprite_anim_sequencer;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       game_run = 1'b0;
  logic [1:0] enemy_type = 2'd0;
  logic       enemy_hit = 1'b0;
  logic       cannon_hit = 1'b0;
  logic       laser_active = 1'b0;
  logic       laser_blast = 1'b0;
  logic [1:0] choose_cannon;
  logic [2:0] choose_laser;
  logic [3:0] choose_enemy;
  logic       enemy_step;
  logic       cannon_busy;
  logic [1:0] dbg_cannon_state;

  int pass_cnt = 0;
  int check_cnt = 0;
  logic [7:0] exp_q[$];

  // ------------------------------------------------------ clock / reset
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached, summary %0d/%0d", pass_cnt, check_cnt);
    $fatal(1, "watchdog");
  end

  sprite_anim_sequencer dut (
    .Clk              (Clk),
    .Reset_n          (Reset_n),
    .frame_tick       (frame_tick),
    .game_run         (game_run),
    .enemy_type       (enemy_type),
    .enemy_hit        (enemy_hit),
    .cannon_hit       (cannon_hit),
    .laser_active     (laser_active),
    .laser_blast      (laser_blast),
    .choose_cannon    (choose_cannon),
    .choose_laser     (choose_laser),
    .choose_enemy     (choose_enemy),
    .enemy_step       (enemy_step),
    .cannon_busy      (cannon_busy),
    .dbg_cannon_state (dbg_cannon_state)
  );

  // ------------------------------------------------------ driver tasks
  task automatic do_reset();
    Reset_n      = 1'b0;
    frame_tick   = 1'b0;
    enemy_hit    = 1'b0;
    cannon_hit   = 1'b0;
    laser_active = 1'b0;
    laser_blast  = 1'b0;
    enemy_type   = 2'd1;
    game_run     = 1'b1;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
  endtask

  // One frame tick: high for one Clk, returns at the negedge after it landed.
  task automatic tick();
    @(negedge Clk) frame_tick = 1'b1;
    @(negedge Clk) frame_tick = 1'b0;
  endtask

  // ------------------------------------------------------ tests
  task automatic test_reset();
    Reset_n = 1'b0;
    enemy_type = 2'd1;
    game_run = 1'b1;
    repeat (2) @(negedge Clk);
    check_cnt++;
    if (choose_enemy !== 4'd2) $display("FAIL reset_enemy: got %0d expected 2", choose_enemy);
    else pass_cnt++;
    check_cnt++;
    if ({choose_cannon, choose_laser, enemy_step, cannon_busy} !== 7'd0)
      $display("FAIL reset_outputs: cannon %0d laser %0d step %0b busy %0b expected all 0",
               choose_cannon, choose_laser, enemy_step, cannon_busy);
    else pass_cnt++;
    enemy_type = 2'd2;
    #1;
    check_cnt++;
    if (choose_enemy !== 4'd4) $display("FAIL reset_enemy_type2: got %0d expected 4", choose_enemy);
    else pass_cnt++;
    enemy_type = 2'd1;
  endtask

  task automatic test_march();
    logic [7:0] e;
    int steps;
    steps = 0;
    do_reset();
    for (int k = 1; k <= 32; k++) begin
      exp_q.push_back({3'b0, (k % 16 == 0), (((k / 16) % 2) != 0) ? 4'd3 : 4'd2});
      tick();
      e = exp_q.pop_front();
      check_cnt++;
      if ({enemy_step, choose_enemy} !== e[4:0])
        $display("FAIL march_tick%0d: step %0b enemy %0d expected step %0b enemy %0d",
                 k, enemy_step, choose_enemy, e[4], e[3:0]);
      else pass_cnt++;
      if (enemy_step === 1'b1) steps++;
      @(negedge Clk);
      check_cnt++;
      if (enemy_step !== 1'b0) $display("FAIL march_step_width%0d: got %0b expected 0", k, enemy_step);
      else pass_cnt++;
    end
    check_cnt++;
    if (steps != 2) $display("FAIL march_step_count: got %0d expected 2", steps);
    else pass_cnt++;
  endtask

  task automatic test_cannon();
    logic [7:0] e;
    logic [1:0] cc, st;
    logic busy;
    do_reset();
    @(negedge Clk) cannon_hit = 1'b1;
    @(negedge Clk) cannon_hit = 1'b0;
    check_cnt++;
    if ({dbg_cannon_state, cannon_busy, choose_cannon} !== 5'b01_1_01)
      $display("FAIL cannon_hit: state %0d busy %0b cannon %0d expected 1 1 1",
               dbg_cannon_state, cannon_busy, choose_cannon);
    else pass_cnt++;
    for (int k = 1; k <= 185; k++) begin
      if (k < 60) begin
        cc = (((k / 4) % 2) != 0) ? 2'd2 : 2'd1;
        st = 2'd1;
      end else if (k < 180) begin
        cc = 2'd3;
        st = 2'd2;
      end else begin
        cc = 2'd0;
        st = 2'd0;
      end
      busy = (k < 180);
      exp_q.push_back({3'b0, st, busy, cc});
      tick();
      e = exp_q.pop_front();
      check_cnt++;
      if ({dbg_cannon_state, cannon_busy, choose_cannon} !== e[4:0])
        $display("FAIL cannon_tick%0d: state %0d busy %0b cannon %0d expected %0d %0b %0d",
                 k, dbg_cannon_state, cannon_busy, choose_cannon, e[4:3], e[2], e[1:0]);
      else pass_cnt++;
      if (k == 30) begin
        @(negedge Clk) cannon_hit = 1'b1;
        @(negedge Clk) cannon_hit = 1'b0;
        check_cnt++;
        if ({dbg_cannon_state, cannon_busy, choose_cannon} !== e[4:0])
          $display("FAIL cannon_rehit: state %0d busy %0b cannon %0d expected %0d %0b %0d",
                   dbg_cannon_state, cannon_busy, choose_cannon, e[4:3], e[2], e[1:0]);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_enemy_blast();
    logic [7:0] e;
    do_reset();
    repeat (5) tick();
    check_cnt++;
    if (choose_enemy !== 4'd2) $display("FAIL blast_pre: got %0d expected 2", choose_enemy);
    else pass_cnt++;
    @(negedge Clk) enemy_hit = 1'b1;
    @(negedge Clk) enemy_hit = 1'b0;
    check_cnt++;
    if (choose_enemy !== 4'd6) $display("FAIL blast_start: got %0d expected 6", choose_enemy);
    else pass_cnt++;
    for (int j = 1; j <= 4; j++) begin
      exp_q.push_back(8'd6);
      tick();
      e = exp_q.pop_front();
      check_cnt++;
      if (choose_enemy !== e[3:0]) $display("FAIL blast_a%0d: got %0d expected %0d", j, choose_enemy, e[3:0]);
      else pass_cnt++;
    end
    @(negedge Clk) enemy_type = 2'd2;
    @(negedge Clk) enemy_type = 2'd1;
    check_cnt++;
    if (choose_enemy !== 4'd6) $display("FAIL blast_type_hidden: got %0d expected 6", choose_enemy);
    else pass_cnt++;
    @(negedge Clk) enemy_hit = 1'b1;
    @(negedge Clk) enemy_hit = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      exp_q.push_back((j < 8) ? 8'd6 : 8'd2);
      tick();
      e = exp_q.pop_front();
      check_cnt++;
      if (choose_enemy !== e[3:0]) $display("FAIL blast_b%0d: got %0d expected %0d", j, choose_enemy, e[3:0]);
      else pass_cnt++;
    end
    // The march was held at step 5: the next toggle comes 11 ticks later.
    for (int j = 1; j <= 11; j++) begin
      exp_q.push_back((j < 11) ? 8'd2 : 8'd3);
      tick();
      e = exp_q.pop_front();
      check_cnt++;
      if (choose_enemy !== e[3:0]) $display("FAIL blast_resume%0d: got %0d expected %0d", j, choose_enemy, e[3:0]);
      else pass_cnt++;
    end
    @(negedge Clk) enemy_type = 2'd3;
    @(negedge Clk);
    check_cnt++;
    if (choose_enemy !== 4'd1) $display("FAIL enemy_type3: got %0d expected 1", choose_enemy);
    else pass_cnt++;
    enemy_type = 2'd2;
    #1;
    check_cnt++;
    if (choose_enemy !== 4'd1) $display("FAIL enemy_type_latency: got %0d expected 1", choose_enemy);
    else pass_cnt++;
    @(negedge Clk);
    check_cnt++;
    if (choose_enemy !== 4'd5) $display("FAIL enemy_type2: got %0d expected 5", choose_enemy);
    else pass_cnt++;
  endtask

  task automatic test_laser();
    logic [7:0] e;
    do_reset();
    @(negedge Clk) laser_active = 1'b1;
    @(negedge Clk);
    for (int k = 1; k <= 18; k++) begin
      exp_q.push_back(8'((k / 4) % 4));
      tick();
      e = exp_q.pop_front();
      check_cnt++;
      if (choose_laser !== e[2:0]) $display("FAIL laser_fly%0d: got %0d expected %0d", k, choose_laser, e[2:0]);
      else pass_cnt++;
    end
    @(negedge Clk) begin
      laser_blast = 1'b1;
      frame_tick  = 1'b1;
    end
    @(negedge Clk) begin
      laser_blast = 1'b0;
      frame_tick  = 1'b0;
    end
    check_cnt++;
    if (choose_laser !== 3'd4) $display("FAIL laser_blast_start: got %0d expected 4", choose_laser);
    else pass_cnt++;
    for (int j = 1; j <= 6; j++) begin
      exp_q.push_back((j < 6) ? 8'd4 : 8'd0);
      tick();
      e = exp_q.pop_front();
      check_cnt++;
      if (choose_laser !== e[2:0]) $display("FAIL laser_blast%0d: got %0d expected %0d", j, choose_laser, e[2:0]);
      else pass_cnt++;
    end
    for (int j = 1; j <= 4; j++) begin
      exp_q.push_back((j < 4) ? 8'd0 : 8'd1);
      tick();
      e = exp_q.pop_front();
      check_cnt++;
      if (choose_laser !== e[2:0]) $display("FAIL laser_after%0d: got %0d expected %0d", j, choose_laser, e[2:0]);
      else pass_cnt++;
    end
    @(negedge Clk) laser_active = 1'b0;
    @(negedge Clk);
    check_cnt++;
    if (choose_laser !== 3'd0) $display("FAIL laser_inactive: got %0d expected 0", choose_laser);
    else pass_cnt++;
  endtask

  task automatic test_freeze();
    logic [7:0] e;
    do_reset();
    repeat (3) tick();
    @(negedge Clk) begin
      game_run     = 1'b0;
      cannon_hit   = 1'b1;
      laser_active = 1'b1;
    end
    @(negedge Clk) cannon_hit = 1'b0;
    check_cnt++;
    if (choose_cannon !== 2'd1) $display("FAIL freeze_hit: got %0d expected 1", choose_cannon);
    else pass_cnt++;
    for (int k = 1; k <= 40; k++) begin
      exp_q.push_back({1'b0, 2'd1, 4'd2, 1'b0});
      tick();
      e = exp_q.pop_front();
      check_cnt++;
      if ({choose_cannon, choose_enemy, enemy_step} !== e[6:0] || choose_laser !== 3'd0)
        $display("FAIL freeze_tick%0d: cannon %0d enemy %0d step %0b laser %0d expected 1 2 0 0",
                 k, choose_cannon, choose_enemy, enemy_step, choose_laser);
      else pass_cnt++;
    end
    @(negedge Clk) begin
      enemy_hit   = 1'b1;
      laser_blast = 1'b1;
    end
    @(negedge Clk) begin
      enemy_hit   = 1'b0;
      laser_blast = 1'b0;
    end
    check_cnt++;
    if (choose_enemy !== 4'd6 || choose_laser !== 3'd4)
      $display("FAIL freeze_events: enemy %0d laser %0d expected 6 4", choose_enemy, choose_laser);
    else pass_cnt++;
    game_run = 1'b1;
    repeat (4) tick();
    check_cnt++;
    if (choose_cannon !== 2'd2 || choose_enemy !== 4'd6 || choose_laser !== 3'd4)
      $display("FAIL freeze_resume: cannon %0d enemy %0d laser %0d expected 2 6 4",
               choose_cannon, choose_enemy, choose_laser);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    do_reset();
    @(negedge Clk) begin
      cannon_hit   = 1'b1;
      laser_active = 1'b1;
    end
    @(negedge Clk) cannon_hit = 1'b0;
    repeat (5) tick();
    @(negedge Clk) laser_blast = 1'b1;
    @(negedge Clk) laser_blast = 1'b0;
    check_cnt++;
    if (choose_cannon !== 2'd2 || cannon_busy !== 1'b1 || choose_laser !== 3'd4)
      $display("FAIL async_pre: cannon %0d busy %0b laser %0d expected 2 1 4",
               choose_cannon, cannon_busy, choose_laser);
    else pass_cnt++;
    @(posedge Clk);
    #3 Reset_n = 1'b0;
    #1;
    check_cnt++;
    if ({dbg_cannon_state, choose_cannon, cannon_busy, choose_laser, enemy_step} !== 9'd0 ||
        choose_enemy !== 4'd2)
      $display("FAIL async_reset: state %0d cannon %0d busy %0b laser %0d step %0b enemy %0d expected 0 0 0 0 0 2",
               dbg_cannon_state, choose_cannon, cannon_busy, choose_laser, enemy_step, choose_enemy);
    else pass_cnt++;
    laser_active = 1'b0;
    @(negedge Clk) Reset_n = 1'b1;
  endtask

  // ------------------------------------------------------ sequence + report
  initial begin
    test_reset();
    test_march();
    test_cannon();
    test_enemy_blast();
    test_laser();
    test_freeze();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
